// File: rtl/mem_arbiter_if.sv
// Bus bundle between minuteCore's fetch/data ports, the arbiter and the shared memory port.
// The slave view belongs to the arbiter. The master view belongs to the core and memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction fetch port
    logic [ADDR_W-1:0] imem_rd_addr;
    logic              imem_rd_enable;
    logic [DATA_W-1:0] imem_rd_data;
    logic              imem_rd_ready;
    // data read/write port
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_r_enable;
    logic              dmem_w_enable;
    logic [DATA_W-1:0] dmem_w_data;
    logic [DATA_W-1:0] dmem_r_data;
    logic              dmem_ready;
    // shared memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_r_enable;
    logic              mem_w_enable;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data;
    logic              mem_ready;

    modport slave (
        input  imem_rd_addr, imem_rd_enable,
        output imem_rd_data, imem_rd_ready,
        input  dmem_addr, dmem_r_enable, dmem_w_enable, dmem_w_data,
        output dmem_r_data, dmem_ready,
        output mem_addr, mem_r_enable, mem_w_enable, mem_w_data,
        input  mem_r_data, mem_ready
    );

    modport master (
        output imem_rd_addr, imem_rd_enable,
        input  imem_rd_data, imem_rd_ready,
        output dmem_addr, dmem_r_enable, dmem_w_enable, dmem_w_data,
        input  dmem_r_data, dmem_ready,
        input  mem_addr, mem_r_enable, mem_w_enable, mem_w_data,
        output mem_r_data, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-into-one memory arbiter. It merges instruction fetch and data access onto one
// wait-state memory port. Round-robin arbitration applies on conflict.
// All outputs come from registers, so there is no input-to-output combinational path.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic GRANT_IMEM = 1'b0;
    localparam logic GRANT_DMEM = 1'b1;

    state_t            state_r, next_state_s;
    // last_grant_r also identifies the requester that owns the current access.
    logic              last_grant_r, last_grant_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_w_data_r, mem_w_data_nxt_s;
    logic              mem_r_en_r, mem_r_en_nxt_s;
    logic              mem_w_en_r, mem_w_en_nxt_s;
    logic [DATA_W-1:0] imem_data_r, imem_data_nxt_s;
    logic [DATA_W-1:0] dmem_data_r, dmem_data_nxt_s;
    logic              imem_ready_r, imem_ready_nxt_s;
    logic              dmem_ready_r, dmem_ready_nxt_s;

    logic              imem_req_s;
    logic              dmem_req_s;
    logic              grant_dmem_s;

    assign imem_req_s   = bus.imem_rd_enable;
    assign dmem_req_s   = bus.dmem_r_enable | bus.dmem_w_enable;
    // On conflict, data wins only if fetch was served last.
    assign grant_dmem_s = dmem_req_s & (~imem_req_s | (last_grant_r == GRANT_IMEM));

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. mem_ready is ignored outside BUSY and requests are ignored in RESP.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (imem_req_s || dmem_req_s) begin
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = BUSY;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs. Everything holds unless a grant or completion occurs.
    always_comb begin
        last_grant_nxt_s = last_grant_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_w_data_nxt_s = mem_w_data_r;
        mem_r_en_nxt_s   = mem_r_en_r;
        mem_w_en_nxt_s   = mem_w_en_r;
        imem_data_nxt_s  = imem_data_r;
        dmem_data_nxt_s  = dmem_data_r;
        imem_ready_nxt_s = 1'b0;
        dmem_ready_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_dmem_s) begin
                    // A simultaneous read and write request is treated as a write.
                    last_grant_nxt_s = GRANT_DMEM;
                    mem_addr_nxt_s   = bus.dmem_addr;
                    mem_w_data_nxt_s = bus.dmem_w_data;
                    mem_w_en_nxt_s   = bus.dmem_w_enable;
                    mem_r_en_nxt_s   = ~bus.dmem_w_enable;
                end else if (imem_req_s) begin
                    last_grant_nxt_s = GRANT_IMEM;
                    mem_addr_nxt_s   = bus.imem_rd_addr;
                    mem_w_data_nxt_s = {DATA_W{1'b0}};
                    mem_w_en_nxt_s   = 1'b0;
                    mem_r_en_nxt_s   = 1'b1;
                end else begin
                    mem_r_en_nxt_s   = 1'b0;
                    mem_w_en_nxt_s   = 1'b0;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    mem_r_en_nxt_s = 1'b0;
                    mem_w_en_nxt_s = 1'b0;
                    if (mem_r_en_r && (last_grant_r == GRANT_DMEM)) begin
                        dmem_data_nxt_s = bus.mem_r_data;
                    end else if (mem_r_en_r) begin
                        imem_data_nxt_s = bus.mem_r_data;
                    end else begin
                        // A write leaves both read-data registers untouched.
                        dmem_data_nxt_s = dmem_data_r;
                    end
                    if (last_grant_r == GRANT_DMEM) begin
                        dmem_ready_nxt_s = 1'b1;
                    end else begin
                        imem_ready_nxt_s = 1'b1;
                    end
                end else begin
                    // Wait state: the memory-side outputs stay stable.
                    mem_addr_nxt_s = mem_addr_r;
                end
            end
            RESP: begin
                mem_r_en_nxt_s = 1'b0;
                mem_w_en_nxt_s = 1'b0;
            end
            default: begin
                mem_r_en_nxt_s = 1'b0;
                mem_w_en_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and arbitration registers. Reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= GRANT_IMEM;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_w_data_r <= {DATA_W{1'b0}};
            mem_r_en_r   <= 1'b0;
            mem_w_en_r   <= 1'b0;
            imem_data_r  <= {DATA_W{1'b0}};
            dmem_data_r  <= {DATA_W{1'b0}};
            imem_ready_r <= 1'b0;
            dmem_ready_r <= 1'b0;
        end else begin
            last_grant_r <= last_grant_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_w_data_r <= mem_w_data_nxt_s;
            mem_r_en_r   <= mem_r_en_nxt_s;
            mem_w_en_r   <= mem_w_en_nxt_s;
            imem_data_r  <= imem_data_nxt_s;
            dmem_data_r  <= dmem_data_nxt_s;
            imem_ready_r <= imem_ready_nxt_s;
            dmem_ready_r <= dmem_ready_nxt_s;
        end
    end

    assign bus.mem_addr      = mem_addr_r;
    assign bus.mem_w_data    = mem_w_data_r;
    assign bus.mem_r_enable  = mem_r_en_r;
    assign bus.mem_w_enable  = mem_w_en_r;
    assign bus.imem_rd_data  = imem_data_r;
    assign bus.imem_rd_ready = imem_ready_r;
    assign bus.dmem_r_data   = dmem_data_r;
    assign bus.dmem_ready    = dmem_ready_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.imem_rd_addr   = 32'h0;
        bus.imem_rd_enable = 1'b0;
        bus.dmem_addr      = 32'h0;
        bus.dmem_r_enable  = 1'b0;
        bus.dmem_w_enable  = 1'b0;
        bus.dmem_w_data    = 32'h0;
        bus.mem_r_data     = 32'h0;
        bus.mem_ready      = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  bus.mem_addr,      32'h0);
        chk({tag, "_wdata"}, bus.mem_w_data,    32'h0);
        chk({tag, "_ren"},   bus.mem_r_enable,  32'h0);
        chk({tag, "_wen"},   bus.mem_w_enable,  32'h0);
        chk({tag, "_idata"}, bus.imem_rd_data,  32'h0);
        chk({tag, "_ddata"}, bus.dmem_r_data,   32'h0);
        chk({tag, "_irdy"},  bus.imem_rd_ready, 32'h0);
        chk({tag, "_drdy"},  bus.dmem_ready,    32'h0);
    endtask

    initial begin
        logic exp_d;
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;

        // Zero-wait fetch: strobe in cycle 1, ready and data in cycle 2.
        bus.imem_rd_addr   = 32'h10;
        bus.imem_rd_enable = 1'b1;
        @(negedge clk);
        chk("t1_ren_c1",  bus.mem_r_enable,  32'd1);
        chk("t1_addr_c1", bus.mem_addr,      32'h10);
        chk("t1_wen_c1",  bus.mem_w_enable,  32'd0);
        chk("t1_irdy_c1", bus.imem_rd_ready, 32'd0);
        bus.mem_ready  = 1'b1;
        bus.mem_r_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_irdy_c2",  bus.imem_rd_ready, 32'd1);
        chk("t1_idata_c2", bus.imem_rd_data,  32'hDEADBEEF);
        chk("t1_ren_c2",   bus.mem_r_enable,  32'd0);
        chk("t1_drdy_c2",  bus.dmem_ready,    32'd0);
        bus.mem_ready      = 1'b0;
        bus.mem_r_data     = 32'h0;
        bus.imem_rd_enable = 1'b0;
        @(negedge clk);
        chk("t1_irdy_c3",  bus.imem_rd_ready, 32'd0);
        chk("t1_idata_c3", bus.imem_rd_data,  32'hDEADBEEF);
        chk("t1_ren_c3",   bus.mem_r_enable,  32'd0);

        // Data write with three wait states: outputs held for four cycles.
        bus.dmem_addr     = 32'h40;
        bus.dmem_w_data   = 32'h1234;
        bus.dmem_w_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_wen",   bus.mem_w_enable, 32'd1);
            chk("t2_ren",   bus.mem_r_enable, 32'd0);
            chk("t2_addr",  bus.mem_addr,     32'h40);
            chk("t2_wdata", bus.mem_w_data,   32'h1234);
            chk("t2_drdy",  bus.dmem_ready,   32'd0);
            if (k == 3) bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        chk("t2_drdy_pulse", bus.dmem_ready,    32'd1);
        chk("t2_wen_off",    bus.mem_w_enable,  32'd0);
        chk("t2_ddata",      bus.dmem_r_data,   32'h0);
        chk("t2_irdy",       bus.imem_rd_ready, 32'd0);
        bus.mem_ready     = 1'b0;
        bus.dmem_w_enable = 1'b0;
        @(negedge clk);
        chk("t2_drdy_end", bus.dmem_ready, 32'd0);

        // Conflict right after reset: D, I, D, I while both requests are held.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.imem_rd_addr   = 32'h100;
        bus.imem_rd_enable = 1'b1;
        bus.dmem_addr      = 32'h200;
        bus.dmem_r_enable  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = ((i % 2) == 0);
            @(negedge clk);
            chk("t3_ren",  bus.mem_r_enable, 32'd1);
            chk("t3_addr", bus.mem_addr, exp_d ? 32'h200 : 32'h100);
            bus.mem_ready  = 1'b1;
            bus.mem_r_data = exp_d ? (32'hD0000000 + 32'(i)) : (32'h10000000 + 32'(i));
            @(negedge clk);
            chk("t3_drdy", bus.dmem_ready,    {31'd0, exp_d});
            chk("t3_irdy", bus.imem_rd_ready, {31'd0, ~exp_d});
            if (exp_d) chk("t3_ddata", bus.dmem_r_data,  32'hD0000000 + 32'(i));
            else       chk("t3_idata", bus.imem_rd_data, 32'h10000000 + 32'(i));
            bus.mem_ready = 1'b0;
            if (i == 3) begin
                bus.imem_rd_enable = 1'b0;
                bus.dmem_r_enable  = 1'b0;
            end
            @(negedge clk);
            chk("t3_idle_ren", bus.mem_r_enable, 32'd0);
        end
        @(negedge clk);
        chk("t3_no_regrant", bus.mem_r_enable, 32'd0);

        // Read and write together: only the write strobe, data register untouched.
        bus.dmem_addr     = 32'h80;
        bus.dmem_w_data   = 32'hABCD;
        bus.dmem_r_enable = 1'b1;
        bus.dmem_w_enable = 1'b1;
        @(negedge clk);
        chk("t4_wen_w0",  bus.mem_w_enable, 32'd1);
        chk("t4_ren_w0",  bus.mem_r_enable, 32'd0);
        chk("t4_addr",    bus.mem_addr,     32'h80);
        @(negedge clk);
        chk("t4_wen_w1",  bus.mem_w_enable, 32'd1);
        chk("t4_ren_w1",  bus.mem_r_enable, 32'd0);
        bus.mem_ready  = 1'b1;
        bus.mem_r_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t4_drdy",  bus.dmem_ready,   32'd1);
        chk("t4_ren",   bus.mem_r_enable, 32'd0);
        chk("t4_ddata", bus.dmem_r_data,  32'hD0000002);
        chk("t4_idata", bus.imem_rd_data, 32'h10000003);
        bus.mem_ready     = 1'b0;
        bus.dmem_r_enable = 1'b0;
        bus.dmem_w_enable = 1'b0;
        @(negedge clk);
        chk("t4_drdy_end", bus.dmem_ready, 32'd0);

        // Reset during a long wait: immediate clear, no ready, then a clean fetch.
        bus.imem_rd_addr   = 32'h20;
        bus.imem_rd_enable = 1'b1;
        @(negedge clk);
        chk("t5_ren_busy", bus.mem_r_enable, 32'd1);
        repeat (2) @(negedge clk);
        chk("t5_ren_wait", bus.mem_r_enable, 32'd1);
        #2 reset = 1'b0;
        #1 chk_all_zero("t5_async");
        bus.imem_rd_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_irdy", bus.imem_rd_ready, 32'd0);
            chk("t5_no_ren",  bus.mem_r_enable,  32'd0);
        end
        bus.imem_rd_addr   = 32'h30;
        bus.imem_rd_enable = 1'b1;
        @(negedge clk);
        chk("t5_ren",  bus.mem_r_enable, 32'd1);
        chk("t5_addr", bus.mem_addr,     32'h30);
        bus.mem_ready  = 1'b1;
        bus.mem_r_data = 32'h5555AAAA;
        @(negedge clk);
        chk("t5_irdy",  bus.imem_rd_ready, 32'd1);
        chk("t5_idata", bus.imem_rd_data,  32'h5555AAAA);
        bus.mem_ready      = 1'b0;
        bus.imem_rd_enable = 1'b0;
        @(negedge clk);
        chk("t5_irdy_end", bus.imem_rd_ready, 32'd0);

        // Stray mem_ready in IDLE is ignored.
        bus.mem_ready  = 1'b1;
        bus.mem_r_data = 32'h77;
        @(negedge clk);
        chk("t6_irdy",  bus.imem_rd_ready, 32'd0);
        chk("t6_drdy",  bus.dmem_ready,    32'd0);
        chk("t6_ren",   bus.mem_r_enable,  32'd0);
        chk("t6_wen",   bus.mem_w_enable,  32'd0);
        chk("t6_idata", bus.imem_rd_data,  32'h5555AAAA);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t6_irdy2", bus.imem_rd_ready, 32'd0);
        chk("t6_drdy2", bus.dmem_ready,    32'd0);
        bus.imem_rd_addr   = 32'h44;
        bus.imem_rd_enable = 1'b1;
        @(negedge clk);
        chk("t6_ren_f",  bus.mem_r_enable,  32'd1);
        chk("t6_addr_f", bus.mem_addr,      32'h44);
        chk("t6_irdy_f", bus.imem_rd_ready, 32'd0);
        bus.mem_ready  = 1'b1;
        bus.mem_r_data = 32'h99;
        @(negedge clk);
        chk("t6_irdy_r",  bus.imem_rd_ready, 32'd1);
        chk("t6_idata_r", bus.imem_rd_data,  32'h99);
        bus.mem_ready      = 1'b0;
        bus.imem_rd_enable = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
